// File: rtl/fg_prog_select_seq.sv
// ---------------------------------------------------------------------------
// fg_prog_select_seq
//   Programming-mux sequencer for one island of indirect FG switch arrays.
//   The block takes one (row, col, mode, npulse) command at a time. It shifts
//   the one-hot row/column select vector serially into the island chain,
//   latches the chain, and then drives timed injection or tunnelling pulses.
//
// Ports
//   clk_i          clock
//   reset_i        asynchronous active-high reset. Release is expected to be
//                  synchronous to clk_i.
//   cmd_valid_i    command present
//   cmd_ready_o    block can accept a command (IDLE only)
//   cmd_row_i      target row index           [RW-1:0]
//   cmd_col_i      target column index        [CW-1:0]
//   cmd_mode_i     00 select-only, 01 inject, 10 tunnel, 11 illegal
//   cmd_npulse_i   pulse count, 0 = select only
//   abort_i        terminate the current command
//   sc_data_o      serial select data, valid together with sc_shift_o
//   sc_shift_o     chain shift strobe
//   sc_latch_o     one-cycle latch of the chain into the mux
//   prog_en_inj_o  injection enable
//   prog_en_tun_o  tunnelling enable
//   busy_o         command in progress
//   done_o         one-cycle completion strobe
//   err_o          qualifies done_o: rejected or aborted
// ---------------------------------------------------------------------------
module fg_prog_select_seq #(
    parameter int ROWS       = 20,
    parameter int COLS       = 32,
    parameter int SETTLE_CYC = 4,
    parameter int PULSE_CYC  = 10,
    parameter int GAP_CYC    = 3,
    localparam int RW        = $clog2(ROWS),
    localparam int CW        = $clog2(COLS),
    localparam int N         = ROWS + COLS
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [RW-1:0] cmd_row_i,
    input  logic [CW-1:0] cmd_col_i,
    input  logic [1:0]    cmd_mode_i,
    input  logic [7:0]    cmd_npulse_i,
    input  logic          abort_i,
    output logic          sc_data_o,
    output logic          sc_shift_o,
    output logic          sc_latch_o,
    output logic          prog_en_inj_o,
    output logic          prog_en_tun_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    // One shared phase counter serves every timed state, so it is sized for the longest one.
    localparam int CM1  = (N > SETTLE_CYC) ? N : SETTLE_CYC;
    localparam int CM2  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CMAX = (CM1 > CM2) ? CM1 : CM2;
    localparam int CNTW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_LATCH, S_SETTLE, S_PULSE, S_GAP, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [7:0]      rem_q, rem_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [1:0]      mode_q, mode_d;
    logic            fail_q, fail_d;

    logic ready_q, busy_q, shift_q, data_q, latch_q, inj_q, tun_q, done_q, err_q;
    logic ready_d, busy_d, shift_d, data_d, latch_d, inj_d, tun_d, done_d, err_d;

    // Bit of {row_onehot, col_onehot} for shift index idx. The vector goes out MSB first,
    // so index 0 carries row ROWS-1 and the last index carries column 0.
    function automatic logic chain_bit(input logic [CNTW-1:0] idx,
                                       input logic [RW-1:0]   r,
                                       input logic [CW-1:0]   c);
        int p;
        p = N - 1 - int'(idx);
        if (p >= COLS) chain_bit = ((p - COLS) == int'(r));
        else           chain_bit = (p == int'(c));
    endfunction

    logic bad_cmd;
    assign bad_cmd = (32'(cmd_row_i) >= ROWS) || (32'(cmd_col_i) >= COLS) ||
                     (cmd_mode_i == 2'b11);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        row_d   = row_q;
        col_d   = col_q;
        mode_d  = mode_q;
        fail_d  = fail_q;
        unique case (state_q)
            S_IDLE: begin
                // cmd_ready is high exactly in IDLE, so valid alone means accept.
                if (cmd_valid_i) begin
                    row_d  = cmd_row_i;
                    col_d  = cmd_col_i;
                    mode_d = cmd_mode_i;
                    rem_d  = cmd_npulse_i;
                    cnt_d  = '0;
                    fail_d = bad_cmd;
                    state_d = bad_cmd ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNTW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = S_LATCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNTW'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = (rem_q != 8'd0 && mode_q != 2'b00) ? S_PULSE : S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_q == CNTW'(PULSE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CNTW'(GAP_CYC - 1)) begin
                    cnt_d = '0;
                    // rem_q >= 1 here, so the decrement never wraps (255 gives 255 pulses).
                    rem_d   = rem_q - 8'd1;
                    state_d = (rem_q > 8'd1) ? S_PULSE : S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i && (state_q inside {S_SHIFT, S_LATCH, S_SETTLE, S_PULSE, S_GAP})) begin
            state_d = S_DONE;
            fail_d  = 1'b1;
        end
    end

    // Outputs are decoded from the next state and then registered, so they line up with
    // state_q and are glitch-free at the chain and the pulse drivers.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        shift_d = (state_d == S_SHIFT);
        data_d  = (state_d == S_SHIFT) && chain_bit(cnt_d, row_d, col_d);
        latch_d = (state_d == S_LATCH);
        inj_d   = (state_d == S_PULSE) && (mode_d == 2'b01);
        tun_d   = (state_d == S_PULSE) && (mode_d == 2'b10);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_DONE) && fail_d;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            mode_q  <= '0;
            fail_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            shift_q <= 1'b0;
            data_q  <= 1'b0;
            latch_q <= 1'b0;
            inj_q   <= 1'b0;
            tun_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
            fail_q  <= fail_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            latch_q <= latch_d;
            inj_q   <= inj_d;
            tun_q   <= tun_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready_o   = ready_q;
    assign busy_o        = busy_q;
    assign sc_shift_o    = shift_q;
    assign sc_data_o     = data_q;
    assign sc_latch_o    = latch_q;
    assign prog_en_inj_o = inj_q;
    assign prog_en_tun_o = tun_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fg_prog_select_seq.sv
// Bench for fg_prog_select_seq. Each command is turned into a cycle-by-cycle
// trace of expected output vectors. The trace is built from the command rules:
// the one-hot vector shifted MSB first, the latch, the settle time, the pulse and
// gap train, and done. The bench compares the DUT against this trace one cycle
// at a time.
module tb_fg_prog_select_seq;
    localparam int ROWS = 20, COLS = 32, SETTLE = 4, PULSE = 10, GAP = 3;
    localparam int N = ROWS + COLS, RW = 5, CW = 5;

    // Output vector bits: {ready, busy, shift, data, latch, inj, tun, done, err}
    localparam logic [8:0] V_IDLE  = 9'h100;
    localparam logic [8:0] B_BUSY  = 9'h080;
    localparam logic [8:0] B_SHIFT = 9'h040;
    localparam logic [8:0] B_DATA  = 9'h020;
    localparam logic [8:0] B_LATCH = 9'h010;
    localparam logic [8:0] B_INJ   = 9'h008;
    localparam logic [8:0] B_TUN   = 9'h004;
    localparam logic [8:0] B_DONE  = 9'h002;
    localparam logic [8:0] B_ERR   = 9'h001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [RW-1:0] cmd_row = '0;
    logic [CW-1:0] cmd_col = '0;
    logic [1:0]    cmd_mode = '0;
    logic [7:0]    cmd_npulse = '0;
    logic          abort = 1'b0;
    logic          sc_data, sc_shift, sc_latch, inj, tun, busy, done, err;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    fg_prog_select_seq dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_row_i(cmd_row), .cmd_col_i(cmd_col),
        .cmd_mode_i(cmd_mode), .cmd_npulse_i(cmd_npulse),
        .abort_i(abort),
        .sc_data_o(sc_data), .sc_shift_o(sc_shift), .sc_latch_o(sc_latch),
        .prog_en_inj_o(inj), .prog_en_tun_o(tun),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] obs();
        return {cmd_ready, busy, sc_shift, sc_data, sc_latch, inj, tun, done, err};
    endfunction

    task automatic check(input string tag, input logic [8:0] o, input logic [8:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // Expected outputs for cycles T+1, T+2, ... after the accept edge T, up to done.
    // abort_c > 0 means abort is high during cycle T+abort_c.
    function automatic void build(input int row, input int col, input int mode,
                                  input int np, input int abort_c);
        logic [N-1:0] vec;
        exp_q.delete();
        if (row >= ROWS || col >= COLS || mode == 3) begin
            exp_q.push_back(B_BUSY | B_DONE | B_ERR);
            return;
        end
        vec = '0;
        vec[COLS + row] = 1'b1;
        vec[col] = 1'b1;
        for (int i = 0; i < N; i++)
            exp_q.push_back(B_BUSY | B_SHIFT | (vec[N-1-i] ? B_DATA : 9'h000));
        exp_q.push_back(B_BUSY | B_LATCH);
        for (int i = 0; i < SETTLE; i++) exp_q.push_back(B_BUSY);
        if (mode != 0 && np != 0) begin
            for (int p = 0; p < np; p++) begin
                for (int i = 0; i < PULSE; i++)
                    exp_q.push_back(B_BUSY | ((mode == 1) ? B_INJ : B_TUN));
                for (int i = 0; i < GAP; i++) exp_q.push_back(B_BUSY);
            end
        end
        exp_q.push_back(B_BUSY | B_DONE);
        // An abort during the done cycle itself is ignored.
        if (abort_c > 0 && abort_c < exp_q.size()) begin
            while (exp_q.size() > abort_c) void'(exp_q.pop_back());
            exp_q.push_back(B_BUSY | B_DONE | B_ERR);
        end
    endfunction

    // Entered and left just after a sampling point (#1 past a rising edge).
    task automatic run(input string tag, input int row, input int col, input int mode,
                       input int np, input int abort_c, input bit hold);
        int w;
        build(row, col, mode, np, abort_c);
        cmd_row    = row[RW-1:0];
        cmd_col    = col[CW-1:0];
        cmd_mode   = mode[1:0];
        cmd_npulse = np[7:0];
        cmd_valid  = 1'b1;
        w = 0;
        while (!cmd_ready && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "_idle_before"}, obs(), V_IDLE);
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            check($sformatf("%s_c%0d", tag, i + 1), obs(), exp_q[i]);
            abort = (abort_c == i + 1);
        end
        abort = 1'b0;
        if (!hold) begin
            @(posedge clk); #1;
            check({tag, "_idle_after"}, obs(), V_IDLE);
        end
    endtask

    task automatic reset_mid(input string tag, input int k);
        build(3, 5, 2, 2, 0);
        cmd_row = 5'd3; cmd_col = 5'd5; cmd_mode = 2'b10; cmd_npulse = 8'd2;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (k - 1) begin @(posedge clk); #1; end
        check({tag, "_pre"}, obs(), exp_q[k-1]);
        reset = 1'b1;
        #1;
        check({tag, "_async"}, obs(), V_IDLE);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check({tag, "_post"}, obs(), V_IDLE);
    endtask

    initial begin
        int row, col, mode, np, ac;
        #12;
        check("reset_state", obs(), V_IDLE);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("after_release", obs(), V_IDLE);

        run("basic_inj",   3,  5, 1,   2,  0, 1'b0);
        run("sel_only",    0,  0, 0,   7,  0, 1'b0);
        run("bad_row",    20,  0, 1,   1,  0, 1'b0);
        run("bad_mode",    2,  2, 3,   1,  0, 1'b0);
        run("abort_tun",   3,  5, 2,   2, 60, 1'b0);
        run("abort_shift", 10, 7, 1,   1,  5, 1'b0);

        abort = 1'b1;
        repeat (3) begin @(posedge clk); #1; check("abort_idle", obs(), V_IDLE); end
        abort = 1'b0;

        run("np_zero",     7,  9, 1,   0,  0, 1'b0);
        run("max_pulse",  19, 31, 2, 255,  0, 1'b0);
        run("b2b_first",   1,  1, 1,   1,  0, 1'b1);
        run("b2b_second",  2,  2, 2,   1,  0, 1'b0);

        reset_mid("rst_shift", 20);
        reset_mid("rst_pulse", 60);

        for (int n = 0; n < 25; n++) begin
            row  = $urandom_range(0, 23);
            col  = $urandom_range(0, 31);
            mode = $urandom_range(0, 3);
            np   = $urandom_range(0, 3);
            build(row, col, mode, np, 0);
            ac = ($urandom_range(0, 2) == 0) ? $urandom_range(1, exp_q.size()) : 0;
            run($sformatf("rnd%0d", n), row, col, mode, np, ac, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
